// File: rtl/cache_status_bank_pkg.sv
// Shared types and helpers for the cache status bank.
// Holds the default geometry, the cache set-index type, and a helper that
// turns an index width into a set count, so every file derives sizes the
// same way.
package cache_status_bank_pkg;

    localparam int DEFAULT_NUM_WAYS    = 8;
    localparam int DEFAULT_INDEX_WIDTH = 3;

    // Cache set index. Widened here so the controller and the status
    // bank agree on the default index size.
    typedef logic [DEFAULT_INDEX_WIDTH-1:0] lc3b_c_index;

    function automatic int num_sets(input int index_width);
        return 1 << index_width;
    endfunction

endpackage

// File: rtl/cache_status_bank_status_way_array.sv
// status_way_array: the valid/dirty store for one cache way.
// Holds NUM_SETS x {valid, dirty} in flops.
// Ports:
//   clk, rst              clock, async active-high reset (clears all bits)
//   rd_index -> rd_*      combinational read for the host-facing outputs
//   scan_index -> scan_*  combinational read for the maintenance engines
//   wr_en/wr_index/wr_*   single-set write
//   clr_en/clr_index      clears both bits of one set (invalidate sweep)
module status_way_array
    import cache_status_bank_pkg::*;
#(
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   rd_valid,
    output logic                   rd_dirty,
    input  logic [INDEX_WIDTH-1:0] scan_index,
    output logic                   scan_valid,
    output logic                   scan_dirty,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic                   wr_valid,
    input  logic                   wr_dirty,
    input  logic                   clr_en,
    input  logic [INDEX_WIDTH-1:0] clr_index
);

    localparam int NUM_SETS = num_sets(INDEX_WIDTH);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;

    // Storage update. The engines never write and clear in the same cycle,
    // so the clear simply takes precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (clr_en) begin
            valid_q[clr_index] <= 1'b0;
            dirty_q[clr_index] <= 1'b0;
        end else if (wr_en) begin
            valid_q[wr_index] <= wr_valid;
            dirty_q[wr_index] <= wr_dirty;
        end
    end

    assign rd_valid   = valid_q[rd_index];
    assign rd_dirty   = dirty_q[rd_index];
    assign scan_valid = valid_q[scan_index];
    assign scan_dirty = dirty_q[scan_index];

endmodule

// File: rtl/cache_status_bank.sv
// cache_status_bank: per-set, per-way valid/dirty status for a
// set-associative cache, with an invalidate-all sweep and a dirty-line scan
// that reports each valid+dirty line to the writeback path.
// Ports:
//   clk, rst                          clock, async active-high reset
//   index                             set for host read and write
//   write, way_sel, valid_in, dirty_in  host write (honoured only when idle)
//   valid_out, dirty_out              all ways at index, combinational
//   inval_all, clean_all              engine start strobes (inval wins)
//   busy, done                        engine active / one-cycle completion pulse
//   wb_valid, wb_index, wb_way        dirty-line report
//   wb_ready                          writeback path accepts the report
module cache_status_bank
    import cache_status_bank_pkg::*;
#(
    parameter  int NUM_WAYS    = DEFAULT_NUM_WAYS,
    parameter  int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    localparam int WAY_WIDTH   = $clog2(NUM_WAYS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic                   write,
    input  logic [WAY_WIDTH-1:0]   way_sel,
    input  logic                   valid_in,
    input  logic                   dirty_in,
    output logic [NUM_WAYS-1:0]    valid_out,
    output logic [NUM_WAYS-1:0]    dirty_out,
    input  logic                   inval_all,
    input  logic                   clean_all,
    output logic                   busy,
    output logic                   done,
    output logic                   wb_valid,
    output logic [INDEX_WIDTH-1:0] wb_index,
    output logic [WAY_WIDTH-1:0]   wb_way,
    input  logic                   wb_ready
);

    typedef enum logic [1:0] {IDLE, INVAL, SCAN, REPORT} state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] ptr;

    logic [NUM_WAYS-1:0]    scan_valid;
    logic [NUM_WAYS-1:0]    scan_dirty;
    logic [NUM_WAYS-1:0]    scan_hits;
    logic [WAY_WIDTH-1:0]   low_way;

    logic                   report_ack;
    logic [WAY_WIDTH-1:0]   wr_way;
    logic [NUM_WAYS-1:0]    wr_en;
    logic [INDEX_WIDTH-1:0] wr_index;
    logic [NUM_WAYS-1:0]    wr_valid;
    logic                   wr_dirty;

    // The writeback acknowledge reuses the host write port: it rewrites the
    // reported line with its own current valid bit and dirty cleared. In
    // REPORT the scan pointer equals wb_index, so scan_valid is that set.
    always_comb begin
        report_ack = (state == REPORT) && wb_ready;
        wr_way     = report_ack ? wb_way : way_sel;
        wr_en      = '0;
        if (report_ack || ((state == IDLE) && write)) begin
            wr_en = {{(NUM_WAYS-1){1'b0}}, 1'b1} << wr_way;
        end
        wr_index   = report_ack ? wb_index : index;
        wr_valid   = report_ack ? scan_valid : {NUM_WAYS{valid_in}};
        wr_dirty   = report_ack ? 1'b0 : dirty_in;
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        status_way_array #(
            .INDEX_WIDTH(INDEX_WIDTH)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .rd_index  (index),
            .rd_valid  (valid_out[w]),
            .rd_dirty  (dirty_out[w]),
            .scan_index(ptr),
            .scan_valid(scan_valid[w]),
            .scan_dirty(scan_dirty[w]),
            .wr_en     (wr_en[w]),
            .wr_index  (wr_index),
            .wr_valid  (wr_valid[w]),
            .wr_dirty  (wr_dirty),
            .clr_en    (state == INVAL),
            .clr_index (ptr)
        );
    end

    // Only lines that are both valid and dirty need writing back; the
    // lowest-numbered such way is reported first.
    always_comb begin
        scan_hits = scan_valid & scan_dirty;
        low_way   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (scan_hits[w]) begin
                low_way = WAY_WIDTH'(w);
            end
        end
    end

    // Maintenance FSM. done is set on the transition back to IDLE so it is
    // high for exactly the first idle cycle. After an acknowledge the same
    // set is rescanned to pick up further dirty ways.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            done     <= 1'b0;
            wb_index <= '0;
            wb_way   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (inval_all) begin
                        state <= INVAL;
                        ptr   <= '0;
                    end else if (clean_all) begin
                        state <= SCAN;
                        ptr   <= '0;
                    end
                end
                INVAL: begin
                    if (&ptr) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                SCAN: begin
                    if (|scan_hits) begin
                        wb_index <= ptr;
                        wb_way   <= low_way;
                        state    <= REPORT;
                    end else if (&ptr) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                REPORT: begin
                    if (wb_ready) begin
                        state <= SCAN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign wb_valid = (state == REPORT);

endmodule

// File: tb/tb_cache_status_bank.sv
// Testbench for cache_status_bank. A reference model (plain arrays) tracks
// the valid/dirty store; each clean_all pushes the expected report sequence
// into a scoreboard queue that an independent monitor drains on every
// wb_valid/wb_ready handshake.
module tb_cache_status_bank;

    localparam int NUM_WAYS    = 8;
    localparam int INDEX_WIDTH = 3;
    localparam int NUM_SETS    = 8;
    localparam int WAY_WIDTH   = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [INDEX_WIDTH-1:0] index;
    logic                   write;
    logic [WAY_WIDTH-1:0]   way_sel;
    logic                   valid_in;
    logic                   dirty_in;
    logic [NUM_WAYS-1:0]    valid_out;
    logic [NUM_WAYS-1:0]    dirty_out;
    logic                   inval_all;
    logic                   clean_all;
    logic                   busy;
    logic                   done;
    logic                   wb_valid;
    logic [INDEX_WIDTH-1:0] wb_index;
    logic [WAY_WIDTH-1:0]   wb_way;
    logic                   wb_ready;

    cache_status_bank dut (
        .clk      (clk),
        .rst      (rst),
        .index    (index),
        .write    (write),
        .way_sel  (way_sel),
        .valid_in (valid_in),
        .dirty_in (dirty_in),
        .valid_out(valid_out),
        .dirty_out(dirty_out),
        .inval_all(inval_all),
        .clean_all(clean_all),
        .busy     (busy),
        .done     (done),
        .wb_valid (wb_valid),
        .wb_index (wb_index),
        .wb_way   (wb_way),
        .wb_ready (wb_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] s;
        logic [WAY_WIDTH-1:0]   w;
    } rep_t;

    int   checks = 0;
    int   errors = 0;
    bit   mv [NUM_SETS][NUM_WAYS];
    bit   md [NUM_SETS][NUM_WAYS];
    rep_t rep_q[$];
    int   done_count = 0;
    int   exp_done   = 0;
    int   wbv_count  = 0;

    function automatic logic [NUM_WAYS-1:0] model_valid(input int s);
        logic [NUM_WAYS-1:0] r;
        for (int w = 0; w < NUM_WAYS; w++) r[w] = mv[s][w];
        return r;
    endfunction

    function automatic logic [NUM_WAYS-1:0] model_dirty(input int s);
        logic [NUM_WAYS-1:0] r;
        for (int w = 0; w < NUM_WAYS; w++) r[w] = md[s][w];
        return r;
    endfunction

    // Expected writeback order: sets ascending, ways ascending, only lines
    // that are both valid and dirty; each reported line ends up clean.
    task automatic modelClean();
        for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++)
                if (mv[s][w] && md[s][w]) begin
                    rep_q.push_back('{s: INDEX_WIDTH'(s), w: WAY_WIDTH'(w)});
                    md[s][w] = 1'b0;
                end
    endtask

    task automatic modelClear();
        for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
            end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host write of one line, one cycle, while idle.
    task automatic applyStimulus(input int s, input int w, input bit v, input bit d);
        write    = 1'b1;
        index    = INDEX_WIDTH'(s);
        way_sel  = WAY_WIDTH'(w);
        valid_in = v;
        dirty_in = d;
        mv[s][w] = v;
        md[s][w] = d;
        tick();
        write = 1'b0;
    endtask

    task automatic checkAll(input string tag);
        for (int s = 0; s < NUM_SETS; s++) begin
            index = INDEX_WIDTH'(s);
            #1;
            checkOutput($sformatf("%s valid_out[%0d]", tag, s), 32'(valid_out), 32'(model_valid(s)));
            checkOutput($sformatf("%s dirty_out[%0d]", tag, s), 32'(dirty_out), 32'(model_dirty(s)));
            tick();
        end
    endtask

    task automatic waitIdle(input string tag);
        int c;
        c = 0;
        while (busy && c < 1000) begin
            tick();
            c++;
        end
        checkOutput({tag, " idle_timeout"}, 32'(busy), 32'd0);
        checkOutput({tag, " done_pulse"}, 32'(done), 32'd1);
        wb_ready = 1'b0;
        tick();
        checkOutput({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    // Dirty scan with optional random backpressure and an optional host
    // write in the start cycle (which must land before the scan begins).
    task automatic runClean(input string tag, input bit rand_ready, input bit with_write);
        int c;
        clean_all = 1'b1;
        if (with_write) begin
            write    = 1'b1;
            index    = INDEX_WIDTH'($urandom_range(0, NUM_SETS - 1));
            way_sel  = WAY_WIDTH'($urandom_range(0, NUM_WAYS - 1));
            valid_in = 1'($urandom_range(0, 1));
            dirty_in = 1'($urandom_range(0, 1));
            mv[index][way_sel] = valid_in;
            md[index][way_sel] = dirty_in;
        end
        modelClean();
        exp_done++;
        tick();
        clean_all = 1'b0;
        write     = 1'b0;
        c = 0;
        while (busy && c < 1000) begin
            wb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            c++;
        end
        waitIdle(tag);
        checkOutput({tag, " scoreboard_drained"}, 32'(rep_q.size()), 32'd0);
    endtask

    task automatic runInval(input string tag);
        int busy_cycles;
        int wbv_before;
        wbv_before = wbv_count;
        inval_all  = 1'b1;
        clean_all  = 1'b1;
        tick();
        inval_all   = 1'b0;
        clean_all   = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 50) begin
            busy_cycles++;
            // Mid-sweep write to an already-swept set must be discarded.
            write = (busy_cycles == 4);
            index = '0;
            way_sel = 3'd3;
            valid_in = 1'b1;
            dirty_in = 1'b1;
            tick();
        end
        write = 1'b0;
        modelClear();
        exp_done++;
        checkOutput({tag, " busy_cycles"}, 32'(busy_cycles), 32'd8);
        waitIdle(tag);
        checkOutput({tag, " no_wb_valid"}, 32'(wbv_count), 32'(wbv_before));
        checkAll(tag);
    endtask

    task automatic waitReport(input string tag);
        int c;
        c = 0;
        while (!wb_valid && c < 100) begin
            tick();
            c++;
        end
        checkOutput({tag, " report_timeout"}, 32'(wb_valid), 32'd1);
    endtask

    // Monitor: drains the scoreboard on each handshake, counts done pulses
    // and any cycle with wb_valid asserted.
    always @(negedge clk) begin
        rep_t e;
        if (!rst) begin
            if (done) done_count++;
            if (wb_valid) wbv_count++;
            if (wb_valid && wb_ready) begin
                if (rep_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL report_unexpected actual=(%0d,%0d) expected=none", wb_index, wb_way);
                end else begin
                    e = rep_q.pop_front();
                    checkOutput("report_index", 32'(wb_index), 32'(e.s));
                    checkOutput("report_way", 32'(wb_way), 32'(e.w));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int done_before;
        rst = 1'b1; index = '0; write = 1'b0; way_sel = '0; valid_in = 1'b0;
        dirty_in = 1'b0; inval_all = 1'b0; clean_all = 1'b0; wb_ready = 1'b0;
        modelClear();
        tick();
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] reset state");
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkAll("reset");

        $display("[TB] single write");
        applyStimulus(3, 5, 1'b1, 1'b1);
        index = 3'd3;
        #1;
        checkOutput("write valid_out[3]", 32'(valid_out), 32'h20);
        checkOutput("write dirty_out[3]", 32'(dirty_out), 32'h20);
        index = 3'd2;
        #1;
        checkOutput("write valid_out[2]", 32'(valid_out), 32'h00);
        tick();

        $display("[TB] directed clean");
        applyStimulus(3, 5, 1'b0, 1'b0);
        applyStimulus(1, 2, 1'b1, 1'b1);
        applyStimulus(6, 0, 1'b1, 1'b1);
        applyStimulus(6, 7, 1'b1, 1'b1);
        applyStimulus(4, 1, 1'b0, 1'b1);
        runClean("clean1", 1'b0, 1'b0);
        index = 3'd6;
        #1;
        checkOutput("clean1 valid_out[6]", 32'(valid_out), 32'h81);
        checkOutput("clean1 dirty_out[6]", 32'(dirty_out), 32'h00);
        checkAll("clean1");

        $display("[TB] report backpressure");
        applyStimulus(2, 4, 1'b1, 1'b1);
        clean_all = 1'b1;
        rep_q.push_back('{s: 3'd2, w: 3'd4});
        exp_done++;
        tick();
        clean_all = 1'b0;
        waitReport("hold");
        for (int k = 0; k < 5; k++) begin
            index = 3'd2;
            #1;
            checkOutput($sformatf("hold%0d wb_valid", k), 32'(wb_valid), 32'd1);
            checkOutput($sformatf("hold%0d wb_index", k), 32'(wb_index), 32'd2);
            checkOutput($sformatf("hold%0d wb_way", k), 32'(wb_way), 32'd4);
            checkOutput($sformatf("hold%0d dirty_out", k), 32'(dirty_out), 32'h10);
            tick();
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        md[2][4] = 1'b0;
        index = 3'd2;
        #1;
        checkOutput("hold_ack dirty_out", 32'(dirty_out), 32'h00);
        checkOutput("hold_ack valid_out", 32'(valid_out), 32'h10);
        tick();
        waitIdle("hold");

        $display("[TB] invalidate sweep");
        for (int s = 0; s < NUM_SETS; s++)
            applyStimulus(s, $urandom_range(0, NUM_WAYS - 1), 1'b1, 1'($urandom_range(0, 1)));
        runInval("inval1");

        $display("[TB] reset during report");
        applyStimulus(5, 1, 1'b1, 1'b1);
        clean_all = 1'b1;
        rep_q.push_back('{s: 3'd5, w: 3'd1});
        tick();
        clean_all = 1'b0;
        waitReport("rstrep");
        index = 3'd5;
        #2;
        rst = 1'b1;
        #1;
        rep_q.delete();
        modelClear();
        checkOutput("rstrep wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rstrep busy", 32'(busy), 32'd0);
        checkOutput("rstrep wb_index", 32'(wb_index), 32'd0);
        checkOutput("rstrep wb_way", 32'(wb_way), 32'd0);
        checkOutput("rstrep valid_out", 32'(valid_out), 32'd0);
        checkOutput("rstrep dirty_out", 32'(dirty_out), 32'd0);
        done_before = done_count;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("rstrep no_done", 32'(done_count), 32'(done_before));

        $display("[TB] random rounds");
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 20; i++)
                applyStimulus($urandom_range(0, NUM_SETS - 1), $urandom_range(0, NUM_WAYS - 1),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            runClean($sformatf("rclean%0d", r), 1'b1, 1'($urandom_range(0, 1)));
            checkAll($sformatf("rclean%0d", r));
            if (r == 3) runInval("rinval");
        end

        checkOutput("done_total", 32'(done_count), 32'(exp_done));
        checkOutput("scoreboard_final", 32'(rep_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
